// File: rtl/moore_pattern_detector_if.sv
// moore_pattern_detector_if: serial bit stream, pattern programming and detector status bundle
interface moore_pattern_detector_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    localparam int FW = $clog2(PAT_W + 1);
    logic             x_in;
    logic             in_valid;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             overlap_en;
    logic             match;
    logic [1:0]       state_out;
    logic [FW-1:0]    fill_cnt;
    logic [CNT_W-1:0] match_count;
    modport master (
        output x_in, in_valid, pat_load, pat_in, overlap_en,
        input  match, state_out, fill_cnt, match_count
    );
    modport slave (
        input  x_in, in_valid, pat_load, pat_in, overlap_en,
        output match, state_out, fill_cnt, match_count
    );
endinterface

// File: rtl/moore_pattern_detector.sv
// moore_pattern_detector: programmable serial pattern Moore detector with saturating match counter
module moore_pattern_detector #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input logic clock,
    input logic reset,
    moore_pattern_detector_if.slave bus
);
    localparam int FW = $clog2(PAT_W + 1);
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_FILL = 2'b01, S_SCAN = 2'b10, S_HIT = 2'b11} state_t;
    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q;
    logic             match_q, acc;
    always_comb begin
        acc = bus.in_valid && state_q != S_IDLE;
        // Truncating the concatenation keeps the newest PAT_W bits, which also covers PAT_W=1
        hist_d = PAT_W'({hist_q, bus.x_in});
        fill_d = (state_q == S_HIT && !bus.overlap_en) ? FW'(1) :
                 (fill_q == FW'(PAT_W)) ? fill_q : fill_q + 1'b1;
        state_d = (fill_d != FW'(PAT_W)) ? S_FILL : (hist_d == pat_q) ? S_HIT : S_SCAN;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
        end else if (bus.pat_load) begin
            state_q <= S_FILL;
            pat_q   <= bus.pat_in;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
        end else if (acc) begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= (state_d == S_HIT && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
            match_q <= state_d == S_HIT;
        end
    end
    assign bus.match       = match_q;
    assign bus.state_out   = state_q;
    assign bus.fill_cnt    = fill_q;
    assign bus.match_count = cnt_q;
endmodule
